led_seq_ctrl: RTL and testbench

// Parametrised LED sequencer for the front-panel/E1 status LEDs. It turns a
// per-LED mode word into blink/flash waveforms and pushes the resulting LED

---
 rtl/led_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_led_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: per-LED blink/flash sequencer that
// pushes changed LED vectors to the SR driver via go/ready.
module led_seq_ctrl #(
  parameter int          N_LEDS       = 4,
  parameter int          TICK_DIV     = 32768,
  parameter logic [15:0] SLOW_PATTERN = 16'hf0f0,
  parameter logic [15:0] FAST_PATTERN = 16'haaaa,
  parameter int          FLASH_TICKS  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3*N_LEDS-1:0] led_mode,
  input  logic [N_LEDS-1:0]   led_trig,
  input  logic                force_upd,
  output logic [N_LEDS-1:0]   led_out,
  output logic [N_LEDS-1:0]   sr_val,
  output logic                sr_go,
  input  logic                sr_rdy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] FLEN = 8'(FLASH_TICKS);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t state;
  state_t state_n;

  logic [PW-1:0]     presc;
  logic [9:0]        cycle;
  logic              tick;
  logic [3:0]        phase;
  logic              blink_slow;
  logic              blink_fast;
  logic [7:0]        flash_cnt [N_LEDS];
  logic [N_LEDS-1:0] led_new;
  logic [N_LEDS-1:0] sr_val_n;
  logic [N_LEDS-1:0] last_sent;
  logic [N_LEDS-1:0] last_sent_n;
  logic              sr_go_n;
  logic              sent_valid;
  logic              sent_valid_n;
  logic              force_flag;
  logic              force_n;
  logic              start;

  assign tick       = (presc == PMAX);
  assign phase      = cycle[9:6];
  assign blink_slow = SLOW_PATTERN[phase];
  assign blink_fast = FAST_PATTERN[phase];

  // prescaler and the tick-driven phase counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cycle <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cycle <= cycle + 10'd1;
    end
  end

  // one-shot flash counters; a trigger reload beats the decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LEDS; i++)
        flash_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (led_trig[i])
          flash_cnt[i] <= FLEN;
        else if (tick && flash_cnt[i] != 8'd0)
          flash_cnt[i] <= flash_cnt[i] - 8'd1;
      end
    end
  end

  // mode/pattern decode into the candidate LED vector
  always_comb begin
    led_new = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (led_mode[3*i +: 3])
        3'd0:    led_new[i] = 1'b0;
        3'd2:    led_new[i] = blink_slow;
        3'd3:    led_new[i] = blink_fast;
        3'd4:    led_new[i] = ~blink_slow;
        3'd5:    led_new[i] = ~blink_fast;
        3'd6:    led_new[i] = (flash_cnt[i] != 8'd0);
        default: led_new[i] = 1'b1;
      endcase
    end
  end

  // LED vector only moves on a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       led_out <= '0;
    else if (tick) led_out <= led_new;
  end

  // handshake state and send bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr_val     <= '0;
      sr_go      <= 1'b0;
      last_sent  <= '0;
      sent_valid <= 1'b0;
      force_flag <= 1'b0;
    end else begin
      state      <= state_n;
      sr_val     <= sr_val_n;
      sr_go      <= sr_go_n;
      last_sent  <= last_sent_n;
      sent_valid <= sent_valid_n;
      force_flag <= force_n;
    end
  end

  // send decision, coalescing and acceptance
  always_comb begin
    state_n      = state;
    sr_val_n     = sr_val;
    sr_go_n      = sr_go;
    last_sent_n  = last_sent;
    sent_valid_n = sent_valid;
    start        = 1'b0;
    case (state)
      IDLE: begin
        if (tick && (led_new != last_sent ||
                     !sent_valid || force_flag)) begin
          start    = 1'b1;
          sr_val_n = led_new;
          sr_go_n  = 1'b1;
          state_n  = PEND;
        end
      end
      PEND: begin
        if (sr_go && sr_rdy) begin
          last_sent_n  = sr_val;
          sent_valid_n = 1'b1;
          sr_go_n      = 1'b0;
          state_n      = IDLE;
        end else if (tick) begin
          sr_val_n = led_new;
        end
      end
    endcase
    // a request arriving as a send starts stays pending
    force_n = (force_flag & ~start) | force_upd;
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: vector table, directed corner cases and
// random stimulus against a tick-level behavioural model.
module tb_led_seq_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int FT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] led_mode = '0;
  logic [3:0]  led_trig = '0;
  logic        force_upd = 1'b0;
  logic        sr_rdy = 1'b0;
  logic [3:0]  led_out;
  logic [3:0]  sr_val;
  logic        sr_go;

  logic [15:0] sp_pat = 16'hf0f0;
  logic [15:0] fp_pat = 16'haaaa;

  int n_cmp = 0;
  int n_bad = 0;

  int       cyc;
  int       ticks;
  int       fl [N];
  logic [3:0] m_led, m_val, m_last;
  bit       m_go, m_valid, m_force, m_tick;
  bit       prev_go;
  int       dut_sends;

  typedef struct {
    logic [11:0] mode;
    logic [3:0]  exp;
  } vec_t;
  vec_t tbl [6];

  led_seq_ctrl #(
    .N_LEDS(N), .TICK_DIV(TD),
    .SLOW_PATTERN(16'hf0f0), .FAST_PATTERN(16'haaaa),
    .FLASH_TICKS(FT)
  ) dut (
    .clk(clk), .rst(rst),
    .led_mode(led_mode), .led_trig(led_trig),
    .force_upd(force_upd),
    .led_out(led_out), .sr_val(sr_val),
    .sr_go(sr_go), .sr_rdy(sr_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // LED value the spec rules give for the ticks seen so far
  function automatic logic [3:0] model_vec();
    int ph;
    logic [3:0] v;
    ph = (ticks / 64) % 16;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (led_mode[3*i +: 3])
        3'd0: v[i] = 1'b0;
        3'd2: v[i] = sp_pat[ph];
        3'd3: v[i] = fp_pat[ph];
        3'd4: v[i] = ~sp_pat[ph];
        3'd5: v[i] = ~fp_pat[ph];
        3'd6: v[i] = (fl[i] != 0);
        default: v[i] = 1'b1;
      endcase
    end
    return v;
  endfunction

  task automatic step();
    logic [3:0] nv;
    bit st;
    @(posedge clk);
    m_tick = (cyc % TD) == TD - 1;
    nv = model_vec();
    st = 0;
    if (m_go && sr_rdy) begin
      m_last = m_val;
      m_valid = 1;
      m_go = 0;
    end else if (m_go) begin
      if (m_tick) m_val = nv;
    end else if (m_tick &&
                 (nv != m_last || !m_valid || m_force)) begin
      st = 1;
      m_val = nv;
      m_go = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (led_trig[i]) fl[i] = FT;
      else if (m_tick && fl[i] > 0) fl[i]--;
    end
    m_force = (m_force && !st) || force_upd;
    if (m_tick) begin
      m_led = nv;
      ticks++;
    end
    cyc++;
    @(negedge clk);
    check("model", {led_out, sr_go, sr_val},
          {m_led, m_go, m_val});
    if (sr_go && !prev_go) dut_sends++;
    prev_go = sr_go;
  endtask

  task automatic run_ticks(input int n);
    int target;
    int guard;
    target = ticks + n;
    guard = 0;
    while (ticks < target && guard < n * TD + 8) begin
      step();
      guard++;
    end
    if (ticks < target) check("tick_timeout", ticks, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out", {led_out, sr_go, sr_val}, 0);
    m_led = 0; m_val = 0; m_last = 0;
    m_go = 0; m_valid = 0; m_force = 0;
    cyc = 0; ticks = 0; prev_go = 0;
    for (int i = 0; i < N; i++) fl[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s0;
    int on;
    tbl[0] = '{{3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000};
    tbl[1] = '{{3'd1, 3'd7, 3'd4, 3'd5}, 4'b1111};
    tbl[2] = '{{3'd2, 3'd3, 3'd6, 3'd1}, 4'b0001};
    tbl[3] = '{{3'd5, 3'd0, 3'd4, 3'd2}, 4'b1010};
    tbl[4] = '{{3'd7, 3'd2, 3'd0, 3'd5}, 4'b1001};
    tbl[5] = '{{3'd3, 3'd1, 3'd3, 3'd4}, 4'b0101};
    dut_sends = 0;

    #2;
    do_reset();
    sr_rdy = 1'b1;
    run_ticks(1);
    check("t1_first_go", sr_go, 1);
    check("t1_first_val", sr_val, 0);
    s0 = dut_sends;
    run_ticks(100);
    check("t1_quiet", dut_sends - s0, 0);

    do_reset();
    for (int k = 0; k < 6; k++) begin
      led_mode = tbl[k].mode;
      run_ticks(1);
      check($sformatf("tbl%0d", k), led_out, tbl[k].exp);
    end

    do_reset();
    led_mode = {9'd0, 3'd3};
    s0 = dut_sends;
    run_ticks(65);
    check("t2_phase1", led_out, 4'b0001);
    run_ticks(1023);
    check("t2_sends", dut_sends - s0, 17);
    check("t2_wrap", led_out, 4'b0000);

    do_reset();
    led_mode = '0;
    run_ticks(2);
    sr_rdy = 1'b0;
    led_mode = {9'd0, 3'd1};
    run_ticks(1);
    check("t3_go", sr_go, 1);
    check("t3_val1", sr_val, 4'b0001);
    led_mode = '0;
    run_ticks(1);
    check("t3_hold_go", sr_go, 1);
    check("t3_coalesce", sr_val, 4'b0000);
    s0 = dut_sends;
    sr_rdy = 1'b1;
    step();
    check("t3_accept", sr_go, 0);
    run_ticks(3);
    check("t3_no_resend", dut_sends - s0, 0);

    led_mode = {3'd0, 3'd6, 6'd0};
    led_trig = 4'b0100;
    step();
    led_trig = '0;
    on = 0;
    for (int k = 0; k < 8; k++) begin
      run_ticks(1);
      if (led_out[2]) on++;
    end
    check("t4_flash_len", on, 3);
    led_trig = 4'b0100;
    step();
    led_trig = '0;
    on = 0;
    for (int k = 0; k < 2; k++) begin
      run_ticks(1);
      if (led_out[2]) on++;
    end
    led_trig = 4'b0100;
    step();
    led_trig = '0;
    for (int k = 0; k < 8; k++) begin
      run_ticks(1);
      if (led_out[2]) on++;
    end
    check("t4_retrig_len", on, 5);

    led_mode = '0;
    run_ticks(2);
    step();
    force_upd = 1'b1;
    step();
    force_upd = 1'b0;
    s0 = dut_sends;
    run_ticks(1);
    check("t5_go", sr_go, 1);
    check("t5_val", sr_val, 4'b0000);
    run_ticks(3);
    check("t5_one_send", dut_sends - s0, 1);

    sr_rdy = 1'b0;
    led_mode = {6'd0, 3'd1, 3'd0};
    run_ticks(1);
    check("t6_pend", sr_go, 1);
    do_reset();
    sr_rdy = 1'b1;
    run_ticks(1);
    check("t6_resend_go", sr_go, 1);
    check("t6_resend_val", sr_val, 4'b0010);

    do_reset();
    led_mode = 12'($urandom);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) led_mode = 12'($urandom);
      led_trig  = ($urandom_range(0, 15) == 0) ?
                  4'($urandom) : 4'd0;
      force_upd = ($urandom_range(0, 19) == 0);
      sr_rdy    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
